// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequencing front-end for a single-port 32x8 data memory.
// It accepts load/store/fill/copy requests over a valid/ready handshake.
// Block operations are serialised one memory access per cycle.
//
// Ports:
//   Clk, Reset        clock (rising edge), asynchronous active-high reset
//   Req_valid/ready   request handshake; Req_ready is high only while idle
//   Req_op            00 load, 01 store, 10 fill, 11 copy
//   Req_addr/src/len  dst start, copy src start, byte count minus one
//   Req_data          store/fill byte
//   Rsp_valid         one-cycle completion pulse
//   Rsp_data          last loaded byte, held until the next load completes
//   Busy              high while a request is in progress
//   Mem_En/Address/Data_in  memory write enable, address and write data
//   Mem_Data_out      combinational memory read data
module mem_access_ctrl (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Req_valid,
    output logic       Req_ready,
    input  logic [1:0] Req_op,
    input  logic [4:0] Req_addr,
    input  logic [4:0] Req_src,
    input  logic [4:0] Req_len,
    input  logic [7:0] Req_data,
    output logic       Rsp_valid,
    output logic [7:0] Rsp_data,
    output logic       Busy,
    output logic       Mem_En,
    output logic [4:0] Mem_Address,
    output logic [7:0] Mem_Data_in,
    input  logic [7:0] Mem_Data_out
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_FILL,
        S_CP_RD,
        S_CP_WR,
        S_RESP
    } state_t;

    state_t          state_q, state_n;
    logic [AW-1:0]   dst_q, dst_n;
    logic [AW-1:0]   src_q, src_n;
    logic [AW-1:0]   cnt_q, cnt_n;
    logic [DW-1:0]   data_q, data_n;
    logic [DW-1:0]   buf_q, buf_n;
    logic [DW-1:0]   rsp_data_q, rsp_data_n;

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            dst_q      <= '0;
            src_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            buf_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_n;
            dst_q      <= dst_n;
            src_q      <= src_n;
            cnt_q      <= cnt_n;
            data_q     <= data_n;
            buf_q      <= buf_n;
            rsp_data_q <= rsp_data_n;
        end
    end

    // Next-state, register updates and memory-port decode
    always_comb begin
        state_n     = state_q;
        dst_n       = dst_q;
        src_n       = src_q;
        cnt_n       = cnt_q;
        data_n      = data_q;
        buf_n       = buf_q;
        rsp_data_n  = rsp_data_q;
        Mem_En      = 1'b0;
        Mem_Address = dst_q;
        Mem_Data_in = data_q;
        Rsp_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req_valid) begin
                    dst_n  = Req_addr;
                    src_n  = Req_src;
                    cnt_n  = Req_len;
                    data_n = Req_data;
                    case (Req_op)
                        OP_LOAD:  state_n = S_LOAD;
                        OP_STORE: state_n = S_STORE;
                        OP_FILL:  state_n = S_FILL;
                        OP_COPY:  state_n = S_CP_RD;
                        default:  state_n = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                rsp_data_n = Mem_Data_out;
                state_n    = S_RESP;
            end
            S_STORE: begin
                Mem_En  = 1'b1;
                state_n = S_RESP;
            end
            S_FILL: begin
                Mem_En = 1'b1;
                if (cnt_q == '0) begin
                    state_n = S_RESP;
                end else begin
                    dst_n = dst_q + AW'(1);
                    cnt_n = cnt_q - AW'(1);
                end
            end
            S_CP_RD: begin
                // Read in its own cycle so it sees every earlier write of this copy
                Mem_Address = src_q;
                buf_n       = Mem_Data_out;
                state_n     = S_CP_WR;
            end
            S_CP_WR: begin
                Mem_En      = 1'b1;
                Mem_Data_in = buf_q;
                if (cnt_q == '0) begin
                    state_n = S_RESP;
                end else begin
                    src_n   = src_q + AW'(1);
                    dst_n   = dst_q + AW'(1);
                    cnt_n   = cnt_q - AW'(1);
                    state_n = S_CP_RD;
                end
            end
            S_RESP: begin
                Rsp_valid = 1'b1;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign Req_ready = (state_q == S_IDLE);
    assign Busy      = (state_q != S_IDLE);
    assign Rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a behavioural 32x8 memory attached.
module tb_mem_access_ctrl;

    logic       Clk;
    logic       Reset;
    logic       Req_valid;
    logic       Req_ready;
    logic [1:0] Req_op;
    logic [4:0] Req_addr;
    logic [4:0] Req_src;
    logic [4:0] Req_len;
    logic [7:0] Req_data;
    logic       Rsp_valid;
    logic [7:0] Rsp_data;
    logic       Busy;
    logic       Mem_En;
    logic [4:0] Mem_Address;
    logic [7:0] Mem_Data_in;
    logic [7:0] Mem_Data_out;

    mem_access_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Req_valid    (Req_valid),
        .Req_ready    (Req_ready),
        .Req_op       (Req_op),
        .Req_addr     (Req_addr),
        .Req_src      (Req_src),
        .Req_len      (Req_len),
        .Req_data     (Req_data),
        .Rsp_valid    (Rsp_valid),
        .Rsp_data     (Rsp_data),
        .Busy         (Busy),
        .Mem_En       (Mem_En),
        .Mem_Address  (Mem_Address),
        .Mem_Data_in  (Mem_Data_in),
        .Mem_Data_out (Mem_Data_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory: combinational read, write on rising edge; every write is logged
    logic [7:0]  mem [32];
    logic [4:0]  wr_addr [256];
    int unsigned wr_cnt = 0;

    assign Mem_Data_out = mem[Mem_Address];

    always @(posedge Clk) begin
        if (Mem_En) begin
            mem[Mem_Address]     <= Mem_Data_in;
            wr_addr[wr_cnt[7:0]] <= Mem_Address;
            wr_cnt               <= wr_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present a request, wait (bounded) for Req_ready, return after the acceptance edge
    task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [4:0] src,
                         input logic [4:0] len, input logic [7:0] data, output int waited);
        Req_op    = op;
        Req_addr  = addr;
        Req_src   = src;
        Req_len   = len;
        Req_data  = data;
        Req_valid = 1'b1;
        waited    = 0;
        while (!Req_ready && waited < 100) begin
            tick();
            waited++;
        end
        tick();
        Req_valid = 1'b0;
    endtask

    // Count cycles after acceptance until Rsp_valid, recording Mem_En per cycle,
    // then step one more cycle and confirm the pulse ended and the block is idle.
    task automatic wait_rsp(input string tag, input int exp_cyc, input logic [31:0] exp_pat);
        int          cyc;
        logic [31:0] pat;
        cyc = 0;
        pat = '0;
        while (!Rsp_valid && cyc < 64) begin
            pat[cyc[4:0]] = Mem_En;
            tick();
            cyc++;
        end
        check({tag, "_rsp_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_en_pattern"}, pat, exp_pat);
        tick();
        check({tag, "_rsp_one_cycle"}, {31'd0, Rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, Req_ready}, 32'd1);
    endtask

    int          w;
    int unsigned base;

    initial begin
        Reset     = 1'b1;
        Req_valid = 1'b0;
        Req_op    = '0;
        Req_addr  = '0;
        Req_src   = '0;
        Req_len   = '0;
        Req_data  = '0;
        tick();
        tick();

        // Reset state
        check("rst_ready", {31'd0, Req_ready}, 32'd1);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, Rsp_valid}, 32'd0);
        check("rst_rsp_data", {24'd0, Rsp_data}, 32'd0);
        check("rst_mem_en", {31'd0, Mem_En}, 32'd0);
        Reset = 1'b0;
        tick();

        // Store 0xA5 @ 7
        base = wr_cnt;
        issue(2'b01, 5'd7, 5'd0, 5'd0, 8'hA5, w);
        check("st_addr", {27'd0, Mem_Address}, 32'd7);
        check("st_wdata", {24'd0, Mem_Data_in}, 32'hA5);
        wait_rsp("store", 1, 32'h1);
        check("st_mem7", {24'd0, mem[7]}, 32'hA5);
        check("st_writes", wr_cnt - base, 32'd1);

        // Load @ 7
        issue(2'b00, 5'd7, 5'd0, 5'd0, 8'h00, w);
        check("ld_addr", {27'd0, Mem_Address}, 32'd7);
        wait_rsp("load", 1, 32'h0);
        check("ld_data", {24'd0, Rsp_data}, 32'hA5);

        // Fill wrapping around the top of memory; address 2 must stay 0x55
        issue(2'b01, 5'd2, 5'd0, 5'd0, 8'h55, w);
        wait_rsp("pre2", 1, 32'h1);
        base = wr_cnt;
        issue(2'b10, 5'd30, 5'd0, 5'd3, 8'h3C, w);
        wait_rsp("fill", 4, 32'hF);
        check("fill_writes", wr_cnt - base, 32'd4);
        check("fill_a0", {27'd0, wr_addr[8'(base)]},     32'd30);
        check("fill_a1", {27'd0, wr_addr[8'(base + 1)]}, 32'd31);
        check("fill_a2", {27'd0, wr_addr[8'(base + 2)]}, 32'd0);
        check("fill_a3", {27'd0, wr_addr[8'(base + 3)]}, 32'd1);
        check("fill_m30", {24'd0, mem[30]}, 32'h3C);
        check("fill_m1", {24'd0, mem[1]}, 32'h3C);
        check("fill_m2_untouched", {24'd0, mem[2]}, 32'h55);

        // Preload 0..7 with 0x10..0x17, then copy 0 -> 16, 8 bytes
        for (int i = 0; i < 8; i++) begin
            issue(2'b01, 5'(i), 5'd0, 5'd0, 8'(8'h10 + i), w);
            wait_rsp("pre", 1, 32'h1);
        end
        base = wr_cnt;
        issue(2'b11, 5'd16, 5'd0, 5'd7, 8'h00, w);
        check("cp_first_rd_addr", {27'd0, Mem_Address}, 32'd0);
        wait_rsp("copy", 16, 32'hAAAA);
        check("cp_writes", wr_cnt - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("cp_byte", {24'd0, mem[16 + i]}, 32'(8'h10 + i));
        end
        issue(2'b00, 5'd23, 5'd0, 5'd0, 8'h00, w);
        wait_rsp("cp_load", 1, 32'h0);
        check("cp_load_data", {24'd0, Rsp_data}, 32'h17);

        // Overlapping copy 4 -> 5, 3 bytes replicates mem[4]
        issue(2'b01, 5'd4, 5'd0, 5'd0, 8'h99, w);
        wait_rsp("pre4", 1, 32'h1);
        issue(2'b11, 5'd5, 5'd4, 5'd2, 8'h00, w);
        wait_rsp("ovl", 6, 32'h2A);
        check("ovl_m4", {24'd0, mem[4]}, 32'h99);
        check("ovl_m5", {24'd0, mem[5]}, 32'h99);
        check("ovl_m6", {24'd0, mem[6]}, 32'h99);
        check("ovl_m7", {24'd0, mem[7]}, 32'h99);
        check("ovl_m3", {24'd0, mem[3]}, 32'h13);

        // Copy onto itself leaves data intact
        base = wr_cnt;
        issue(2'b11, 5'd16, 5'd16, 5'd1, 8'h00, w);
        wait_rsp("self", 4, 32'hA);
        check("self_writes", wr_cnt - base, 32'd2);
        check("self_m16", {24'd0, mem[16]}, 32'h10);
        check("self_m17", {24'd0, mem[17]}, 32'h11);

        // Request held during a busy fill is taken once the block is idle again
        base = wr_cnt;
        issue(2'b10, 5'd20, 5'd0, 5'd3, 8'h5A, w);
        check("hold_busy", {31'd0, Req_ready}, 32'd0);
        issue(2'b01, 5'd25, 5'd0, 5'd0, 8'hC3, w);
        check("hold_wait_cycles", 32'(w), 32'd5);
        wait_rsp("hold_st", 1, 32'h1);
        check("hold_writes", wr_cnt - base, 32'd5);
        check("hold_m25", {24'd0, mem[25]}, 32'hC3);
        check("hold_m23", {24'd0, mem[23]}, 32'h5A);

        // Reset in the middle of a fill: two bytes land, then everything stops
        issue(2'b10, 5'd8, 5'd0, 5'd7, 8'hEE, w);
        wait_rsp("prefill", 8, 32'hFF);
        base = wr_cnt;
        issue(2'b10, 5'd8, 5'd0, 5'd7, 8'h77, w);
        tick();
        tick();
        check("mid_en_before", {31'd0, Mem_En}, 32'd1);
        Reset     = 1'b1;
        Req_valid = 1'b1;
        Req_op    = 2'b01;
        #1;
        check("mid_en_drop", {31'd0, Mem_En}, 32'd0);
        check("mid_busy", {31'd0, Busy}, 32'd0);
        check("mid_ready", {31'd0, Req_ready}, 32'd1);
        tick();
        tick();
        check("mid_no_accept", {31'd0, Busy}, 32'd0);
        check("mid_no_rsp", {31'd0, Rsp_valid}, 32'd0);
        check("mid_rsp_data", {24'd0, Rsp_data}, 32'd0);
        Req_valid = 1'b0;
        Reset     = 1'b0;
        tick();
        tick();
        check("mid_rsp_after", {31'd0, Rsp_valid}, 32'd0);
        check("mid_writes", wr_cnt - base, 32'd2);
        check("mid_m8", {24'd0, mem[8]}, 32'h77);
        check("mid_m9", {24'd0, mem[9]}, 32'h77);
        check("mid_m10", {24'd0, mem[10]}, 32'hEE);
        check("mid_m15", {24'd0, mem[15]}, 32'hEE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
